// File: rtl/data_axi_burst_interface_pkg.sv
// Shared types and AXI encodings for the data-cache AXI bridge.
package data_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

endpackage

// File: rtl/data_axi_burst_interface_if.sv
// AXI3 channel bundle between the cache bridge (master) and the interconnect (slave).
interface data_axi_burst_interface_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [3:0]        rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [3:0]        awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [3:0]        wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/data_axi_burst_interface_line_buffer.sv
// Cache-line staging buffer: parallel load, beat-indexed write and read.
module data_line_buffer #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          load,
  input  logic [32*LINE_WORDS-1:0]      load_data,
  input  logic                          wr_en,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_idx,
  input  logic [31:0]                   wr_data,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_idx,
  output logic [31:0]                   rd_data,
  output logic [32*LINE_WORDS-1:0]      line_nxt
);

  logic [32*LINE_WORDS-1:0] line_q;
  logic [32*LINE_WORDS-1:0] line_d;

  // Next line contents; exported so a final beat can be forwarded the same cycle.
  always_comb begin
    line_d = line_q;
    if (load) begin
      line_d = load_data;
    end else if (wr_en) begin
      line_d[{wr_idx, 5'd0} +: 32] = wr_data;
    end
  end

  // Line storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign rd_data  = line_q[{rd_idx, 5'd0} +: 32];
  assign line_nxt = line_d;

endmodule

// File: rtl/data_axi_burst_interface.sv
// AXI3 master bridge for the data cache: single-word uncached accesses and line bursts.
module data_axi_burst_interface
  import data_axi_pkg::*;
#(
  parameter logic [3:0]  AXI_ID     = 4'h1,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic                     req_burst,
  input  logic [2:0]               req_size,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [3:0]               req_wstrb,
  input  logic [32*LINE_WORDS-1:0] req_wdata,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [32*LINE_WORDS-1:0] resp_rdata,
  output logic                     resp_err,
  data_axi_burst_interface_if.master axi
);

  localparam int unsigned IDX_W  = $clog2(LINE_WORDS);
  localparam int unsigned BEAT_W = IDX_W + 1;
  localparam int unsigned OFF_W  = $clog2(LINE_WORDS * 4);
  localparam logic [BEAT_W-1:0] LAST_BURST = BEAT_W'(LINE_WORDS - 1);

  state_e                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic                     err_q, err_d;
  logic                     burst_q, burst_d;
  logic [3:0]               ax_id_q, ax_id_d;
  logic [ADDR_W-1:0]        ax_addr_q, ax_addr_d;
  logic [7:0]               ax_len_q, ax_len_d;
  logic [2:0]               ax_size_q, ax_size_d;
  logic [1:0]               ax_burst_q, ax_burst_d;
  logic                     arvalid_q, arvalid_d;
  logic                     awvalid_q, awvalid_d;
  logic                     rready_q, rready_d;
  logic                     wvalid_q, wvalid_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [3:0]               wstrb_q, wstrb_d;
  logic                     wlast_q, wlast_d;
  logic                     bready_q, bready_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_err_q, resp_err_d;
  logic [32*LINE_WORDS-1:0] resp_rdata_q, resp_rdata_d;

  logic                     accept;
  logic                     r_fire;
  logic                     b_fire;
  logic [BEAT_W-1:0]        last_beat;
  logic                     buf_load;
  logic                     buf_wr;
  logic [IDX_W-1:0]         rd_idx;
  logic [31:0]              buf_rd;
  logic [32*LINE_WORDS-1:0] buf_line_nxt;

  assign req_ready = resetn && enable && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign last_beat = burst_q ? LAST_BURST : '0;

  // Foreign-ID beats are left unconsumed by holding READY low on them.
  assign r_fire = rready_q && axi.rvalid && (axi.rid == AXI_ID);
  assign b_fire = bready_q && axi.bvalid && (axi.bid == AXI_ID);

  // Buffer control kept outside the FSM so forwarded line data has no comb loop.
  // In W the word for the following beat is prefetched into the WDATA register.
  assign buf_load = (state_q == ST_IDLE) && accept;
  assign buf_wr   = (state_q == ST_R) && r_fire;
  assign rd_idx   = beat_q[IDX_W-1:0] + IDX_W'(state_q == ST_W);

  data_line_buffer #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buffer (
    .clk       (clk),
    .resetn    (resetn),
    .load      (buf_load),
    .load_data (req_write ? req_wdata : '0),
    .wr_en     (buf_wr),
    .wr_idx    (beat_q[IDX_W-1:0]),
    .wr_data   (axi.rdata),
    .rd_idx    (rd_idx),
    .rd_data   (buf_rd),
    .line_nxt  (buf_line_nxt)
  );

  // Transfer sequencing and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    err_d        = err_q;
    burst_d      = burst_q;
    ax_id_d      = ax_id_q;
    ax_addr_d    = ax_addr_q;
    ax_len_d     = ax_len_q;
    ax_size_d    = ax_size_q;
    ax_burst_d   = ax_burst_q;
    arvalid_d    = arvalid_q;
    awvalid_d    = awvalid_q;
    rready_d     = rready_q;
    wvalid_d     = wvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wlast_d      = wlast_q;
    bready_d     = bready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          beat_d     = '0;
          err_d      = 1'b0;
          burst_d    = req_burst;
          ax_id_d    = AXI_ID;
          ax_burst_d = AXI_BURST_INCR;
          if (req_burst) begin
            ax_addr_d = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            ax_len_d  = 8'(LINE_WORDS - 1);
            ax_size_d = AXI_SIZE_WORD;
            wstrb_d   = '1;
          end else begin
            ax_addr_d = req_addr;
            ax_len_d  = '0;
            ax_size_d = req_size;
            wstrb_d   = req_wstrb;
          end
          if (req_write) begin
            state_d   = ST_AW;
            awvalid_d = 1'b1;
          end else begin
            state_d   = ST_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_AR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (r_fire) begin
          err_d = err_q | (axi.rresp != AXI_RESP_OKAY);
          if (axi.rlast || (beat_q == last_beat)) begin
            rready_d     = 1'b0;
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = err_d;
            resp_rdata_d = buf_line_nxt;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_AW: begin
        if (axi.awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wdata_d   = buf_rd;
          wlast_d   = (beat_q == last_beat);
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (axi.wready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = ST_B;
          end else begin
            wdata_d = buf_rd;
            wlast_d = (beat_d == last_beat);
          end
        end
      end
      ST_B: begin
        if (b_fire) begin
          bready_d     = 1'b0;
          err_d        = err_q | (axi.bresp != AXI_RESP_OKAY);
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = err_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears everything, even mid-transfer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      err_q        <= 1'b0;
      burst_q      <= 1'b0;
      ax_id_q      <= '0;
      ax_addr_q    <= '0;
      ax_len_q     <= '0;
      ax_size_q    <= '0;
      ax_burst_q   <= '0;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      burst_q      <= burst_d;
      ax_id_q      <= ax_id_d;
      ax_addr_q    <= ax_addr_d;
      ax_len_q     <= ax_len_d;
      ax_size_q    <= ax_size_d;
      ax_burst_q   <= ax_burst_d;
      arvalid_q    <= arvalid_d;
      awvalid_q    <= awvalid_d;
      rready_q     <= rready_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wlast_q      <= wlast_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;

  assign axi.arid    = ax_id_q;
  assign axi.araddr  = ax_addr_q;
  assign axi.arlen   = ax_len_q;
  assign axi.arsize  = ax_size_q;
  assign axi.arburst = ax_burst_q;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q && (axi.rid == AXI_ID);

  assign axi.awid    = ax_id_q;
  assign axi.awaddr  = ax_addr_q;
  assign axi.awlen   = ax_len_q;
  assign axi.awsize  = ax_size_q;
  assign axi.awburst = ax_burst_q;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;
  assign axi.awvalid = awvalid_q;

  assign axi.wid     = ax_id_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = wlast_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q && (axi.bid == AXI_ID);

endmodule

// File: tb/tb_data_axi_burst_interface.sv
// Directed self-checking bench for the data-cache AXI bridge.
module tb_data_axi_burst_interface;

  logic         clk = 1'b0;
  logic         resetn;
  logic         enable;
  logic         req_valid;
  logic         req_write;
  logic         req_burst;
  logic [2:0]   req_size;
  logic [31:0]  req_addr;
  logic [3:0]   req_wstrb;
  logic [127:0] req_wdata;
  logic         req_ready;
  logic         resp_valid;
  logic [127:0] resp_rdata;
  logic         resp_err;

  int total = 0;
  int bad   = 0;

  data_axi_burst_interface_if #(.ADDR_W(32)) axi ();

  data_axi_burst_interface #(
    .AXI_ID     (4'h1),
    .LINE_WORDS (4),
    .ADDR_W     (32)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_burst  (req_burst),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wstrb  (req_wstrb),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi        (axi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    axi.arready = 1'b0;
    axi.rid     = 4'h1;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.rvalid  = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bid     = 4'h1;
    axi.bresp   = 2'b00;
    axi.bvalid  = 1'b0;
  endtask

  task automatic set_req(input logic wr, input logic bu, input logic [2:0] sz,
                         input logic [31:0] ad, input logic [3:0] st, input logic [127:0] wd);
    req_write = wr;
    req_burst = bu;
    req_size  = sz;
    req_addr  = ad;
    req_wstrb = st;
    req_wdata = wd;
    req_valid = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
    total++; if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0) begin
      bad++; $display("FAIL rst_valids got=%b want=00000", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}); end
    total++; if ({resp_valid, resp_err} !== 2'b00) begin bad++; $display("FAIL rst_resp got=%b want=00", {resp_valid, resp_err}); end
    total++; if (resp_rdata !== 128'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", resp_rdata); end
    total++; if (axi.arid !== 4'h0) begin bad++; $display("FAIL rst_arid got=%h want=0", axi.arid); end
    resetn = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b want=1", req_ready); end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL en_ready got=%b want=0", req_ready); end
    set_req(1'b0, 1'b0, 3'd2, 32'h0000_0100, 4'hF, '0);
    tick();
    total++; if (axi.arvalid !== 1'b0) begin bad++; $display("FAIL en_no_accept got=%b want=0", axi.arvalid); end
    req_valid = 1'b0;
    enable    = 1'b1;
  endtask

  task automatic test_single_read();
    axi.arready = 1'b1;
    set_req(1'b0, 1'b0, 3'd2, 32'h1000_0004, 4'hF, '0);
    tick();                                   // accept edge, cycle 1
    req_valid = 1'b0;
    total++; if (axi.arvalid !== 1'b1) begin bad++; $display("FAIL sr_arvalid got=%b want=1", axi.arvalid); end
    total++; if (axi.araddr !== 32'h1000_0004) begin bad++; $display("FAIL sr_araddr got=%h want=10000004", axi.araddr); end
    total++; if ({axi.arlen, axi.arsize, axi.arburst} !== {8'd0, 3'd2, 2'b01}) begin
      bad++; $display("FAIL sr_arfields got=%h/%h/%h want=00/2/1", axi.arlen, axi.arsize, axi.arburst); end
    total++; if ({axi.arid, axi.arlock, axi.arcache, axi.arprot} !== {4'h1, 2'b0, 4'h0, 3'b0}) begin
      bad++; $display("FAIL sr_arid_attr got=%h want=1 with zero attributes", {axi.arid, axi.arlock, axi.arcache, axi.arprot}); end
    tick();                                   // cycle 2
    axi.arready = 1'b0;
    total++; if (axi.rready !== 1'b1) begin bad++; $display("FAIL sr_rready got=%b want=1", axi.rready); end
    axi.rvalid = 1'b1; axi.rid = 4'h1; axi.rdata = 32'hDEAD_BEEF; axi.rresp = 2'b00; axi.rlast = 1'b1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL sr_early_resp got=%b want=0", resp_valid); end
    tick();                                   // cycle 3
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL sr_resp_valid got=%b want=1", resp_valid); end
    total++; if (resp_rdata[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sr_rdata got=%h want=deadbeef", resp_rdata[31:0]); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL sr_err got=%b want=0", resp_err); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL sr_ready_in_done got=%b want=0", req_ready); end
    tick();                                   // cycle 4
    total++; if ({resp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL sr_after got=%b want=01", {resp_valid, req_ready}); end
  endtask

  task automatic test_burst_read();
    logic [31:0] beats [4];
    beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33; beats[3] = 32'h44;
    axi.arready = 1'b1;
    set_req(1'b0, 1'b1, 3'd0, 32'h0000_203C, 4'h0, '0);
    tick();
    req_valid = 1'b0;
    total++; if (axi.araddr !== 32'h0000_2030) begin bad++; $display("FAIL br_araddr got=%h want=00002030", axi.araddr); end
    total++; if ({axi.arlen, axi.arsize, axi.arburst} !== {8'd3, 3'd2, 2'b01}) begin
      bad++; $display("FAIL br_arfields got=%h/%h/%h want=03/2/1", axi.arlen, axi.arsize, axi.arburst); end
    tick();
    axi.arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL br_early_resp beat=%0d got=%b want=0", k, resp_valid); end
      axi.rvalid = 1'b1; axi.rid = 4'h1; axi.rdata = beats[k]; axi.rresp = 2'b00; axi.rlast = (k == 3);
      tick();
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
    end
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL br_resp_valid got=%b want=1", resp_valid); end
    total++; if (resp_rdata !== 128'h00000044_00000033_00000022_00000011) begin
      bad++; $display("FAIL br_rdata got=%h want=00000044000000330000002200000011", resp_rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL br_err got=%b want=0", resp_err); end
    tick();
  endtask

  task automatic test_foreign_id();
    axi.arready = 1'b1;
    set_req(1'b0, 1'b0, 3'd2, 32'h0000_3000, 4'hF, '0);
    tick();
    req_valid = 1'b0;
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rid = 4'h2; axi.rdata = 32'hBAD0_BAD0; axi.rlast = 1'b1; axi.rresp = 2'b10;
    #1;
    total++; if (axi.rready !== 1'b0) begin bad++; $display("FAIL fid_rready got=%b want=0", axi.rready); end
    tick();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL fid_consumed got=%b want=0", resp_valid); end
    axi.rid = 4'h1; axi.rdata = 32'h600D_F00D; axi.rresp = 2'b00;
    #1;
    total++; if (axi.rready !== 1'b1) begin bad++; $display("FAIL fid_rready_own got=%b want=1", axi.rready); end
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL fid_resp_valid got=%b want=1", resp_valid); end
    total++; if (resp_rdata[31:0] !== 32'h600D_F00D) begin bad++; $display("FAIL fid_rdata got=%h want=600df00d", resp_rdata[31:0]); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL fid_err got=%b want=0", resp_err); end
    tick();
  endtask

  task automatic test_burst_write();
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    set_req(1'b1, 1'b1, 3'd0, 32'h0000_4000, 4'h0, 128'h000000A3_000000A2_000000A1_000000A0);
    tick();                                   // cycle 1: AW
    req_valid = 1'b0;
    total++; if ({axi.awvalid, axi.awaddr, axi.awlen, axi.awsize} !== {1'b1, 32'h4000, 8'd3, 3'd2}) begin
      bad++; $display("FAIL bw_aw got=%b/%h/%h/%h want=1/00004000/03/2", axi.awvalid, axi.awaddr, axi.awlen, axi.awsize); end
    tick();                                   // cycle 2: beat 0
    axi.awready = 1'b0;
    total++; if ({axi.wvalid, axi.wdata, axi.wlast, axi.wstrb, axi.wid} !== {1'b1, 32'hA0, 1'b0, 4'hF, 4'h1}) begin
      bad++; $display("FAIL bw_beat0 got=%b/%h/%b/%h/%h want=1/000000a0/0/f/1", axi.wvalid, axi.wdata, axi.wlast, axi.wstrb, axi.wid); end
    tick();                                   // cycle 3: beat 1, stalled three cycles
    axi.wready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) axi.wready = 1'b1;
      total++; if ({axi.wvalid, axi.wdata, axi.wlast} !== {1'b1, 32'hA1, 1'b0}) begin
        bad++; $display("FAIL bw_beat1_hold cyc=%0d got=%b/%h/%b want=1/000000a1/0", s, axi.wvalid, axi.wdata, axi.wlast); end
      tick();
    end
    total++; if ({axi.wvalid, axi.wdata, axi.wlast} !== {1'b1, 32'hA2, 1'b0}) begin
      bad++; $display("FAIL bw_beat2 got=%b/%h/%b want=1/000000a2/0", axi.wvalid, axi.wdata, axi.wlast); end
    tick();
    total++; if ({axi.wvalid, axi.wdata, axi.wlast} !== {1'b1, 32'hA3, 1'b1}) begin
      bad++; $display("FAIL bw_beat3 got=%b/%h/%b want=1/000000a3/1", axi.wvalid, axi.wdata, axi.wlast); end
    tick();
    axi.wready = 1'b0;
    total++; if ({axi.wvalid, axi.bready} !== 2'b01) begin bad++; $display("FAIL bw_to_b got=%b want=01", {axi.wvalid, axi.bready}); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bw_early_resp got=%b want=0", resp_valid); end
    axi.bvalid = 1'b1; axi.bid = 4'h1; axi.bresp = 2'b10;
    tick();
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    total++; if ({resp_valid, resp_err} !== 2'b11) begin bad++; $display("FAIL bw_resp got=%b want=11", {resp_valid, resp_err}); end
    total++; if (resp_rdata[31:0] !== 32'h600D_F00D) begin bad++; $display("FAIL bw_rdata_hold got=%h want=600df00d", resp_rdata[31:0]); end
    tick();
  endtask

  task automatic test_single_write_delay();
    int aw_cycles;
    aw_cycles = 0;
    axi.awready = 1'b0;
    axi.arready = 1'b0;
    set_req(1'b1, 1'b0, 3'd2, 32'h0000_5008, 4'b0011, {96'h0, 32'h1234_5678});
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) axi.awready = 1'b1;
      if (axi.awvalid === 1'b1) aw_cycles++;
      total++; if (axi.awaddr !== 32'h0000_5008) begin bad++; $display("FAIL sw_awaddr cyc=%0d got=%h want=00005008", c, axi.awaddr); end
      tick();
    end
    axi.awready = 1'b0;
    axi.wready  = 1'b1;
    total++; if (aw_cycles != 6 || axi.awvalid !== 1'b0) begin
      bad++; $display("FAIL sw_aw_hold got=%0d/%b want=6/0", aw_cycles, axi.awvalid); end
    total++; if ({axi.wvalid, axi.wstrb, axi.wdata, axi.wlast} !== {1'b1, 4'b0011, 32'h1234_5678, 1'b1}) begin
      bad++; $display("FAIL sw_w got=%b/%b/%h/%b want=1/0011/12345678/1", axi.wvalid, axi.wstrb, axi.wdata, axi.wlast); end
    tick();
    axi.wready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if ({resp_valid, axi.bready} !== 2'b01) begin bad++; $display("FAIL sw_wait_b cyc=%0d got=%b want=01", c, {resp_valid, axi.bready}); end
      tick();
    end
    axi.bvalid = 1'b1; axi.bid = 4'h1; axi.bresp = 2'b00;
    tick();
    axi.bvalid = 1'b0;
    total++; if ({resp_valid, resp_err} !== 2'b10) begin bad++; $display("FAIL sw_resp got=%b want=10", {resp_valid, resp_err}); end
    tick();
  endtask

  task automatic test_reset_mid();
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    set_req(1'b1, 1'b1, 3'd0, 32'h0000_6000, 4'h0, 128'h000000B3_000000B2_000000B1_000000B0);
    tick();
    req_valid = 1'b0;
    tick();
    axi.awready = 1'b0;
    tick();
    total++; if (axi.wdata !== 32'hB1) begin bad++; $display("FAIL rm_beat1 got=%h want=000000b1", axi.wdata); end
    tick();
    total++; if (axi.wdata !== 32'hB2) begin bad++; $display("FAIL rm_beat2 got=%h want=000000b2", axi.wdata); end
    resetn = 1'b0;
    tick();
    total++; if ({axi.wvalid, axi.awvalid, axi.arvalid, axi.bready, axi.rready, axi.wlast, resp_valid, resp_err, req_ready} !== 9'b0) begin
      bad++; $display("FAIL rm_ctrl_zero got=%b want=000000000",
                      {axi.wvalid, axi.awvalid, axi.arvalid, axi.bready, axi.rready, axi.wlast, resp_valid, resp_err, req_ready}); end
    total++; if ({axi.wdata, axi.wid, axi.awaddr, resp_rdata} !== '0) begin
      bad++; $display("FAIL rm_data_zero got=%h/%h/%h/%h want=0", axi.wdata, axi.wid, axi.awaddr, resp_rdata); end
    axi.wready = 1'b0;
    resetn = 1'b1;
    axi.arready = 1'b1;
    set_req(1'b0, 1'b0, 3'd2, 32'h0000_7000, 4'hF, '0);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b want=1", req_ready); end
    tick();
    req_valid = 1'b0;
    total++; if ({axi.arvalid, axi.araddr} !== {1'b1, 32'h7000}) begin
      bad++; $display("FAIL rm_new_read got=%b/%h want=1/00007000", axi.arvalid, axi.araddr); end
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rid = 4'h1; axi.rdata = 32'hCAFE_0001; axi.rlast = 1'b1;
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    total++; if ({resp_valid, resp_rdata[31:0]} !== {1'b1, 32'hCAFE_0001}) begin
      bad++; $display("FAIL rm_read_done got=%b/%h want=1/cafe0001", resp_valid, resp_rdata[31:0]); end
    tick();
  endtask

  initial begin
    resetn    = 1'b0;
    enable    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_burst = 1'b0;
    req_size  = '0;
    req_addr  = '0;
    req_wstrb = '0;
    req_wdata = '0;
    slave_idle();
    #1;
    test_reset();
    test_enable();
    test_single_read();
    test_burst_read();
    test_foreign_id();
    test_burst_write();
    test_single_write_delay();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
